phase_sequencer: RTL and testbench

Multi-cycle phase sequencer for the MIPS core: owns the one-hot phase vector `p[4:0]` consumed by the control unit, and decides per instruction how many phases run and when to stall. Phases stall on the memory handshake (fetch and load/store) and on the multi-cycle multiply/divide unit. The block detects unsupported encodings, overflow faults and handshake timeouts, and keeps retired-instruction and active-cycle counters.

---
 rtl/phase_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_phase_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - multi-cycle phase sequencer for the MIPS control unit
//
// Purpose: owns the one-hot phase vector consumed by the control unit and
// decides per instruction which phases run and when to stall on memory or
// multiply/divide. Detects illegal encodings, overflow and handshake
// timeouts (sticky halt) and keeps retired-instruction / active-cycle counts.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   run        in   enable, sampled in IDLE and at instruction boundaries
//   op         in   [5:0] IR opcode (valid from P1)
//   irfunc     in   [5:0] IR funct field
//   regimm     in   [4:0] IR rt field
//   mem_ready  in   memory completion (honoured in P0 and LOAD/STORE P3)
//   mdu_done   in   multiply/divide result ready
//   error      in   ALU overflow flag (honoured in P4)
//   p          out  [4:0] one-hot phase, 0 in IDLE/HALT
//   mem_req    out  memory request
//   mdu_start  out  one-cycle MDU start pulse
//   halted     out  sticky halt indicator
//   halt_code  out  [1:0] 01 illegal, 10 overflow, 11 timeout
//   retired    out  [CNT_W-1:0] completed-instruction count
//   cycles     out  [CNT_W-1:0] count of P0-P4 cycles

module phase_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       irfunc,
    input  logic [4:0]       regimm,
    input  logic             mem_ready,
    input  logic             mdu_done,
    input  logic             error,
    output logic [4:0]       p,
    output logic             mem_req,
    output logic             mdu_start,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_BRANCH, C_STORE, C_LOAD, C_MULDIV, C_OTHER, C_ILLEGAL
    } cls_t;

    localparam logic [1:0] HC_ILLEGAL  = 2'b01;
    localparam logic [1:0] HC_OVERFLOW = 2'b10;
    localparam logic [1:0] HC_TIMEOUT  = 2'b11;

    state_t            r_state;
    cls_t              r_cls;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_halt_code;
    logic [CNT_W-1:0]  r_retired;
    logic [CNT_W-1:0]  r_cycles;

    state_t            w_state_nxt;
    state_t            w_boundary;
    cls_t              w_cls;
    cls_t              w_cls_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [1:0]        w_halt_code_nxt;
    logic              w_retire;
    logic              w_stall;
    logic              w_done;
    logic              w_active;

    // Instruction decode, only consumed while in P1.
    always_comb begin
        w_cls = C_ILLEGAL;
        case (op)
            6'h00: begin
                case (irfunc)
                    6'h18, 6'h19, 6'h1A, 6'h1B:
                        w_cls = C_MULDIV;
                    6'h00, 6'h02, 6'h03, 6'h06, 6'h07, 6'h08, 6'h09,
                    6'h10, 6'h11, 6'h12, 6'h13,
                    6'h20, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:
                        w_cls = C_OTHER;
                    default:
                        w_cls = C_ILLEGAL;
                endcase
            end
            6'h01:                       w_cls = (regimm == 5'h00 || regimm == 5'h01) ? C_BRANCH : C_ILLEGAL;
            6'h04, 6'h05, 6'h06, 6'h07:  w_cls = C_BRANCH;
            6'h02, 6'h03, 6'h09,
            6'h0A, 6'h0B, 6'h0C, 6'h0D,
            6'h0E, 6'h0F:                w_cls = C_OTHER;
            6'h20, 6'h21, 6'h23,
            6'h24, 6'h25:                w_cls = C_LOAD;
            6'h28, 6'h29, 6'h2B:         w_cls = C_STORE;
            default:                     w_cls = C_ILLEGAL;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cls_nxt       = r_cls;
        w_halt_code_nxt = r_halt_code;
        w_retire        = 1'b0;
        w_stall         = 1'b0;
        w_done          = 1'b0;
        w_boundary      = run ? S_P0 : S_IDLE;

        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_P0;
            end
            S_P0: begin
                w_stall = 1'b1;
                w_done  = mem_ready;
                if (mem_ready) w_state_nxt = S_P1;
            end
            S_P1: begin
                w_cls_nxt = w_cls;
                if (w_cls == C_ILLEGAL) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = HC_ILLEGAL;
                end else begin
                    w_state_nxt = S_P2;
                end
            end
            S_P2: begin
                if (r_cls == C_MULDIV) begin
                    // r_wait is 0 only in the start-pulse cycle, so a done
                    // seen there belongs to a previous operation.
                    w_stall = 1'b1;
                    w_done  = mdu_done && (r_wait != '0);
                    if (w_done) w_state_nxt = S_P4;
                end else if (r_cls == C_BRANCH) begin
                    w_retire    = 1'b1;
                    w_state_nxt = w_boundary;
                end else if (r_cls == C_LOAD || r_cls == C_STORE) begin
                    w_state_nxt = S_P3;
                end else begin
                    w_state_nxt = S_P4;
                end
            end
            S_P3: begin
                w_stall = 1'b1;
                w_done  = mem_ready;
                if (mem_ready) begin
                    if (r_cls == C_STORE) begin
                        w_retire    = 1'b1;
                        w_state_nxt = w_boundary;
                    end else begin
                        w_state_nxt = S_P4;
                    end
                end
            end
            S_P4: begin
                if (error) begin
                    w_state_nxt     = S_HALT;
                    w_halt_code_nxt = HC_OVERFLOW;
                end else begin
                    w_retire    = 1'b1;
                    w_state_nxt = w_boundary;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Completion in the last allowed cycle beats the timeout.
        if (w_stall && !w_done && r_wait == WAIT_W'(TIMEOUT - 1)) begin
            w_state_nxt     = S_HALT;
            w_halt_code_nxt = HC_TIMEOUT;
        end
    end

    always_comb begin
        if (w_state_nxt != r_state) w_wait_nxt = '0;
        else if (w_stall)           w_wait_nxt = r_wait + WAIT_W'(1);
        else                        w_wait_nxt = r_wait;
    end

    assign w_active = (r_state == S_P0) || (r_state == S_P1) || (r_state == S_P2) ||
                      (r_state == S_P3) || (r_state == S_P4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cls       <= C_OTHER;
            r_wait      <= '0;
            r_halt_code <= 2'b00;
            r_retired   <= '0;
            r_cycles    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cls       <= w_cls_nxt;
            r_wait      <= w_wait_nxt;
            r_halt_code <= w_halt_code_nxt;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
            if (w_active) r_cycles  <= r_cycles + CNT_W'(1);
        end
    end

    always_comb begin
        p = 5'b00000;
        case (r_state)
            S_P0:    p = 5'b00001;
            S_P1:    p = 5'b00010;
            S_P2:    p = 5'b00100;
            S_P3:    p = 5'b01000;
            S_P4:    p = 5'b10000;
            default: p = 5'b00000;
        endcase
    end

    assign mem_req   = (r_state == S_P0) || (r_state == S_P3);
    assign mdu_start = (r_state == S_P2) && (r_cls == C_MULDIV) && (r_wait == '0);
    assign halted    = (r_state == S_HALT);
    assign halt_code = r_halt_code;
    assign retired   = r_retired;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - scoreboard bench for phase_sequencer

module tb_phase_sequencer;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 64;

    // Phase indices used by the reference model.
    localparam int PH_IDLE = 5;
    localparam int PH_HALT = 6;

    localparam int K_BR = 0, K_ST = 1, K_LD = 2, K_MD = 3, K_OT = 4, K_IL = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic [5:0]       op = 6'h00;
    logic [5:0]       irfunc = 6'h00;
    logic [4:0]       regimm = 5'h00;
    logic             mem_ready = 1'b0;
    logic             mdu_done = 1'b0;
    logic             error = 1'b0;
    logic [4:0]       p;
    logic             mem_req;
    logic             mdu_start;
    logic             halted;
    logic [1:0]       halt_code;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] cycles;

    phase_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .op        (op),
        .irfunc    (irfunc),
        .regimm    (regimm),
        .mem_ready (mem_ready),
        .mdu_done  (mdu_done),
        .error     (error),
        .p         (p),
        .mem_req   (mem_req),
        .mdu_start (mdu_start),
        .halted    (halted),
        .halt_code (halt_code),
        .retired   (retired),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]       p;
        logic             mem_req;
        logic             mdu_start;
        logic             halted;
        logic [1:0]       code;
        logic [CNT_W-1:0] ret;
        logic [CNT_W-1:0] cyc;
    } exp_t;

    exp_t             q[$];
    int               n_vec = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] m_ret = '0;
    logic [CNT_W-1:0] m_cyc = '0;
    logic [1:0]       m_code = 2'b00;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction class straight from the encoding table.
    function automatic int cls_of(input logic [5:0] o, input logic [5:0] f, input logic [4:0] rt);
        if (o inside {[6'h04:6'h07]} || (o == 6'h01 && rt inside {5'h00, 5'h01})) return K_BR;
        if (o inside {6'h28, 6'h29, 6'h2B}) return K_ST;
        if (o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return K_LD;
        if (o == 6'h00 && f inside {[6'h18:6'h1B]}) return K_MD;
        if (o inside {6'h02, 6'h03, 6'h09, [6'h0A:6'h0F]}) return K_OT;
        if (o == 6'h00 && f inside {6'h00, 6'h02, 6'h03, 6'h06, 6'h07, 6'h08, 6'h09,
                                    [6'h10:6'h13], 6'h20, [6'h22:6'h27], 6'h2A, 6'h2B}) return K_OT;
        return K_IL;
    endfunction

    // One clock cycle: drive inputs, record what the outputs must be during
    // this cycle, then advance the model counters.
    task automatic cyc(input int ph, input bit mr, input bit md, input bit er,
                       input bit rn, input bit ms, input bit ret);
        exp_t e;
        mem_ready = mr;
        mdu_done  = md;
        error     = er;
        run       = rn;
        e.p         = (ph < 5) ? 5'(1 << ph) : 5'b00000;
        e.mem_req   = (ph == 0 || ph == 3);
        e.mdu_start = ms;
        e.halted    = (ph == PH_HALT);
        e.code      = m_code;
        e.ret       = m_ret;
        e.cyc       = m_cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (ph < 5) m_cyc = m_cyc + 1;
        if (ret)    m_ret = m_ret + 1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        m_ret  = '0;
        m_cyc  = '0;
        m_code = 2'b00;
        cyc(PH_IDLE, rb(), rb(), rb(), rb(), 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic start_from_idle();
        repeat ($urandom_range(0, 2)) cyc(PH_IDLE, rb(), rb(), rb(), 1'b0, 1'b0, 1'b0);
        cyc(PH_IDLE, rb(), rb(), rb(), 1'b1, 1'b0, 1'b0);
    endtask

    // Stalling phase whose completion arrives in cycle d (0-based); a
    // completion that never comes in time gives TIMEOUT cycles then HALT.
    task automatic stall(input int ph, input int d, input bit fin, input bit ra, output bit to);
        int n;
        n  = (d < TIMEOUT) ? d + 1 : TIMEOUT;
        to = (d >= TIMEOUT);
        for (int k = 0; k < n; k++) begin
            bit rdy;
            bit comp_in;
            bit rn;
            rdy     = (k == d);
            comp_in = rdy ? 1'b1 : ((ph == 2 && k == 0) ? rb() : 1'b0);
            rn      = (rdy && fin) ? ra : rb();
            if (ph == 2) cyc(ph, rb(), comp_in, rb(), rn, k == 0, rdy && fin);
            else         cyc(ph, comp_in, rb(), rb(), rn, 1'b0, rdy && fin);
        end
    endtask

    // st: 0 completed, 1 halted, 2 reset during P3.
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] rt,
                            input int d0, input int d3, input int dm, input bit err,
                            input bit ra, input bit rp3, output int st);
        int k;
        bit to;
        k  = cls_of(o, f, rt);
        st = 0;
        op     = 6'($urandom);
        irfunc = 6'($urandom);
        regimm = 5'($urandom);
        stall(0, d0, 1'b0, 1'b0, to);
        if (to) begin m_code = 2'b11; st = 1; return; end
        op     = o;
        irfunc = f;
        regimm = rt;
        cyc(1, rb(), rb(), rb(), rb(), 1'b0, 1'b0);
        if (k == K_IL) begin m_code = 2'b01; st = 1; return; end
        if (k == K_BR) begin
            cyc(2, rb(), rb(), rb(), ra, 1'b0, 1'b1);
            return;
        end
        if (k == K_MD) begin
            stall(2, dm, 1'b0, 1'b0, to);
            if (to) begin m_code = 2'b11; st = 1; return; end
        end else begin
            cyc(2, rb(), rb(), rb(), rb(), 1'b0, 1'b0);
        end
        if (k == K_LD || k == K_ST) begin
            if (rp3 && k == K_ST) begin
                cyc(3, 1'b0, rb(), rb(), rb(), 1'b0, 1'b0);
                cyc(3, 1'b0, rb(), rb(), rb(), 1'b0, 1'b0);
                do_reset();
                st = 2;
                return;
            end
            stall(3, d3, k == K_ST, ra, to);
            if (to) begin m_code = 2'b11; st = 1; return; end
            if (k == K_ST) return;
        end
        cyc(4, rb(), rb(), err, err ? rb() : ra, 1'b0, !err);
        if (err) begin m_code = 2'b10; st = 1; end
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] rt,
                             input int d0, input int d3, input int dm, input bit err,
                             input bit ra, input bit rp3);
        int st;
        do_instr(o, f, rt, d0, d3, dm, err, ra, rp3, st);
        if (st == 1) begin
            repeat ($urandom_range(1, 3)) cyc(PH_HALT, rb(), rb(), rb(), rb(), 1'b0, 1'b0);
            do_reset();
            start_from_idle();
        end else if (st == 2 || !ra) begin
            start_from_idle();
        end
    endtask

    // Monitor: one expected vector per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                g = '{p: p, mem_req: mem_req, mdu_start: mdu_start, halted: halted,
                      code: halt_code, ret: retired, cyc: cycles};
                n_vec++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL vec%0d got p=%b req=%b ms=%b h=%b code=%b ret=%0d cyc=%0d, exp p=%b req=%b ms=%b h=%b code=%b ret=%0d cyc=%0d",
                             n_vec, g.p, g.mem_req, g.mdu_start, g.halted, g.code, g.ret, g.cyc,
                             e.p, e.mem_req, e.mdu_start, e.halted, e.code, e.ret, e.cyc);
                end
            end
        end
    end

    logic [5:0] opl [0:24] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h28, 6'h29, 6'h2B,
                               6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h00, 6'h00, 6'h00,
                               6'h02, 6'h03, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0] fnl [0:23] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00, 6'h02, 6'h03, 6'h06,
                               6'h07, 6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13, 6'h20,
                               6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        logic [4:0] rt;
        int d0, d3, dm;
        bit err, ra, rp3;

        @(posedge clk);
        #1;
        do_reset();
        start_from_idle();

        // Directed: op, funct, rt, d0, d3, dm, err, run_after, reset_in_p3
        run_instr(6'h23, 6'h00, 5'h00, 0,  0, 1,  1'b0, 1'b1, 1'b0); // lw
        run_instr(6'h04, 6'h00, 5'h00, 0,  0, 1,  1'b0, 1'b1, 1'b0); // beq
        run_instr(6'h00, 6'h20, 5'h00, 0,  0, 1,  1'b0, 1'b0, 1'b0); // add, then idle
        run_instr(6'h00, 6'h20, 5'h00, 3,  0, 1,  1'b0, 1'b1, 1'b0); // fetch stall 3
        run_instr(6'h00, 6'h1A, 5'h00, 0,  0, 5,  1'b0, 1'b1, 1'b0); // div, done 5 after P2 entry
        run_instr(6'h00, 6'h18, 5'h00, 0,  0, 1,  1'b0, 1'b1, 1'b0); // mult, minimum P2
        run_instr(6'h2B, 6'h00, 5'h00, 0,  2, 1,  1'b0, 1'b1, 1'b0); // sw with P3 stall
        run_instr(6'h23, 6'h00, 5'h00, 63, 63, 1, 1'b0, 1'b1, 1'b0); // completion in last cycle
        run_instr(6'h00, 6'h19, 5'h00, 0,  0, 63, 1'b0, 1'b1, 1'b0); // MDU done in last cycle
        run_instr(6'h01, 6'h00, 5'h01, 0,  0, 1,  1'b0, 1'b1, 1'b0); // bgez
        run_instr(6'h01, 6'h00, 5'h02, 0,  0, 1,  1'b0, 1'b1, 1'b0); // bad regimm -> illegal
        run_instr(6'h3F, 6'h00, 5'h00, 0,  0, 1,  1'b0, 1'b1, 1'b0); // illegal
        run_instr(6'h00, 6'h20, 5'h00, 0,  0, 1,  1'b1, 1'b0, 1'b0); // overflow with run=0
        run_instr(6'h2B, 6'h00, 5'h00, 0,  5, 1,  1'b0, 1'b1, 1'b1); // reset during P3 of sw
        run_instr(6'h23, 6'h00, 5'h00, 64, 0, 1,  1'b0, 1'b1, 1'b0); // fetch timeout
        run_instr(6'h21, 6'h00, 5'h00, 0,  70, 1, 1'b0, 1'b1, 1'b0); // P3 timeout
        run_instr(6'h00, 6'h1B, 5'h00, 0,  0, 64, 1'b0, 1'b1, 1'b0); // MDU timeout

        for (int i = 0; i < 300; i++) begin
            o  = opl[$urandom_range(0, 24)];
            f  = fnl[$urandom_range(0, 23)];
            rt = 5'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) begin
                o  = 6'($urandom);
                f  = 6'($urandom);
            end
            if ($urandom_range(0, 5) == 0) rt = 5'($urandom);
            d0  = ($urandom_range(0, 39) == 0) ? $urandom_range(60, 66) : $urandom_range(0, 3);
            d3  = ($urandom_range(0, 39) == 0) ? $urandom_range(60, 66) : $urandom_range(0, 3);
            dm  = ($urandom_range(0, 39) == 0) ? $urandom_range(60, 66) : $urandom_range(1, 6);
            err = ($urandom_range(0, 11) == 0);
            ra  = ($urandom_range(0, 4) != 0);
            rp3 = ($urandom_range(0, 19) == 0);
            run_instr(o, f, rt, d0, d3, dm, err, ra, rp3);
        end

        @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected vectors never compared, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
